// File: rtl/simple_result_reducer.sv
// Accumulates a fixed-length run of upstream results into one sum, with a
// sticky carry flag, and holds the sum on a valid/ready output until taken.
module simple_result_reducer #(
  parameter int DataWidth = 64,
  parameter int CntWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CntWidth-1:0]  len_i,
  output logic                 busy_o,
  input  logic [DataWidth-1:0] result_i,
  input  logic                 result_valid_i,
  output logic                 result_ready_o,
  output logic [DataWidth-1:0] sum_o,
  output logic                 sum_valid_o,
  input  logic                 sum_ready_i,
  output logic [CntWidth-1:0]  count_o,
  output logic                 overflow_o
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  len_q, cnt_q;
  logic [DataWidth-1:0] acc_q;
  logic                 ovf_q;

  logic                 start_ok, accept, last;
  logic [DataWidth:0]   add_w;
  logic [CntWidth:0]    cnt_inc;

  assign start_ok = (state_q == IDLE) && start_i && (len_i != '0);
  assign accept   = (state_q == ACC) && result_valid_i;
  assign add_w    = {1'b0, acc_q} + {1'b0, result_i};
  // One extra bit so len = 2^CntWidth-1 compares without wrapping.
  assign cnt_inc  = {1'b0, cnt_q} + {{CntWidth{1'b0}}, 1'b1};
  assign last     = accept && (cnt_inc == {1'b0, len_q});

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)    state_d = ACC;
      ACC:     if (last)        state_d = OUT;
      OUT:     if (sum_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath only moves on an accepted start or an accept, so OUT holds everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (start_ok) begin
      len_q <= len_i;
      cnt_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= cnt_inc[CntWidth-1:0];
      acc_q <= add_w[DataWidth-1:0];
      ovf_q <= ovf_q | add_w[DataWidth];
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign result_ready_o = (state_q == ACC);
  assign sum_valid_o    = (state_q == OUT);
  assign sum_o          = acc_q;
  assign count_o        = cnt_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_simple_result_reducer.sv
// Scenario bench for simple_result_reducer: directed cases plus random
// reductions checked against a wide-integer sum model.
module tb_simple_result_reducer;
  localparam int DW = 64;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] len_i = '0;
  logic [DW-1:0] result_i = '0;
  logic          result_valid_i = 1'b0;
  logic          sum_ready_i = 1'b0;
  logic          busy_o, result_ready_o, sum_valid_o, overflow_o;
  logic [DW-1:0] sum_o;
  logic [CW-1:0] count_o;

  simple_result_reducer #(.DataWidth(DW), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .result_i(result_i), .result_valid_i(result_valid_i),
    .result_ready_o(result_ready_o), .sum_o(sum_o), .sum_valid_o(sum_valid_o),
    .sum_ready_i(sum_ready_i), .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] vals[$];

  // Reference: exact integer sum; any carry ever produced means the total reached 2^DW.
  function automatic logic [DW:0] model();
    logic [127:0] big = '0;
    foreach (vals[i]) big += {64'd0, vals[i]};
    return {big[127:64] != 0, big[63:0]};
  endfunction

  task automatic do_start(input int len);
    start_i = 1'b1; len_i = CW'(len);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Drives vals with gap idle cycles before each (gap<0: random 0..3); ok drops
  // if ready was ever low or a sum appeared before the final accept.
  task automatic feed(input int gap, output bit ok);
    ok = 1'b1;
    foreach (vals[i]) begin
      int g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin
        if (!result_ready_o || sum_valid_o) ok = 1'b0;
        result_valid_i = 1'b0;
        @(negedge clk);
      end
      if (!result_ready_o || sum_valid_o) ok = 1'b0;
      result_valid_i = 1'b1; result_i = vals[i];
      @(negedge clk);
    end
    result_valid_i = 1'b0;
  endtask

  // Holds sum_ready low for hold cycles, requiring the expected sum steady, then handshakes.
  task automatic drain(input int hold, input logic [DW-1:0] es, input int ec,
                       input bit eo, output bit ok);
    ok = 1'b1;
    repeat (hold + 1) begin
      if (!sum_valid_o || sum_o !== es || count_o !== CW'(ec) || overflow_o !== eo ||
          result_ready_o || !busy_o) ok = 1'b0;
      if (hold-- == 0) sum_ready_i = 1'b1;
      @(negedge clk);
    end
    sum_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    start_i = 1'b1; len_i = 8'd3;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({busy_o, result_ready_o, sum_valid_o, overflow_o, sum_o, count_o} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got busy=%0b rdy=%0b sv=%0b ovf=%0b sum=%0h cnt=%0d, want all 0",
                 busy_o, result_ready_o, sum_valid_o, overflow_o, sum_o, count_o);
      end
    end
    start_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after_release: busy=%0b want 0", busy_o); end
  endtask

  task automatic test_basic();
    bit ok;
    do_start(3);
    n_checks++;
    if (busy_o !== 1'b1 || result_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL basic_enter_acc: busy=%0b rdy=%0b want 1 1", busy_o, result_ready_o);
    end
    vals = '{64'd1, 64'd2, 64'd3};
    feed(0, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_feed: ok=%0b want 1", ok); end
    n_checks++;
    if (sum_valid_o !== 1'b1 || sum_o !== 64'd6 || count_o !== 8'd3 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sum: sv=%0b sum=%0d cnt=%0d ovf=%0b want 1 6 3 0",
               sum_valid_o, sum_o, count_o, overflow_o);
    end
    drain(0, 64'd6, 3, 1'b0, ok);
    n_checks++;
    if (ok !== 1'b1 || sum_valid_o !== 1'b0 || busy_o !== 1'b0 || sum_o !== 64'd6) begin
      n_fail++;
      $display("FAIL basic_handshake: ok=%0b sv=%0b busy=%0b sum=%0d want 1 0 0 6",
               ok, sum_valid_o, busy_o, sum_o);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_start(2);
    vals = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    feed(0, ok);
    n_checks++;
    if (ok !== 1'b1 || sum_valid_o !== 1'b1 || sum_o !== 64'd0 || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: ok=%0b sv=%0b sum=%0h ovf=%0b want 1 1 0 1",
               ok, sum_valid_o, sum_o, overflow_o);
    end
    drain(1, 64'd0, 2, 1'b1, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL overflow_hold: ok=%0b want 1", ok); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit stable = 1'b1;
    do_start(2);
    vals = '{64'h1234, 64'h1111};
    feed(3, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_feed_gaps: ok=%0b want 1", ok); end
    repeat (5) begin
      if (sum_valid_o !== 1'b1 || sum_o !== 64'h2345 || count_o !== 8'd2) stable = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable: stable=%0b want 1", stable); end
    // Start coinciding with the output handshake must not launch a reduction.
    sum_ready_i = 1'b1; start_i = 1'b1; len_i = 8'd7;
    @(negedge clk);
    sum_ready_i = 1'b0; start_i = 1'b0;
    n_checks++;
    if (sum_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: sv=%0b busy=%0b want 0 0", sum_valid_o, busy_o);
    end
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || sum_o !== 64'h2345) begin
      n_fail++; $display("FAIL bp_start_ignored: busy=%0b sum=%0h want 0 2345", busy_o, sum_o);
    end
  endtask

  task automatic test_len_zero();
    bit bad = 1'b0;
    start_i = 1'b1; len_i = 8'd0;
    repeat (4) begin
      @(negedge clk);
      if (busy_o || result_ready_o || sum_valid_o) bad = 1'b1;
    end
    start_i = 1'b0;
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL len_zero: activity=%0b want 0", bad); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    do_start(4);
    vals = '{64'd10, 64'd20};
    feed(0, ok);
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, result_ready_o, sum_valid_o, overflow_o, sum_o, count_o} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy=%0b rdy=%0b sv=%0b ovf=%0b sum=%0h cnt=%0d want all 0",
               busy_o, result_ready_o, sum_valid_o, overflow_o, sum_o, count_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    do_start(1);
    n_checks++;
    if (busy_o !== 1'b1 || sum_valid_o !== 1'b0 || count_o !== 8'd0) begin
      n_fail++; $display("FAIL abort_first_start: busy=%0b sv=%0b cnt=%0d want 1 0 0",
                         busy_o, sum_valid_o, count_o);
    end
    vals = '{64'd5};
    feed(0, ok);
    n_checks++;
    if (ok !== 1'b1 || sum_valid_o !== 1'b1 || sum_o !== 64'd5 || count_o !== 8'd1) begin
      n_fail++; $display("FAIL abort_new_sum: ok=%0b sv=%0b sum=%0d cnt=%0d want 1 1 5 1",
                         ok, sum_valid_o, sum_o, count_o);
    end
    drain(0, 64'd5, 1, 1'b0, ok);
  endtask

  task automatic test_start_in_acc();
    bit ok;
    do_start(2);
    vals = '{64'd100};
    feed(0, ok);
    start_i = 1'b1; len_i = 8'd7;
    @(negedge clk);
    start_i = 1'b0;
    vals = '{64'd23};
    feed(1, ok);
    n_checks++;
    if (ok !== 1'b1 || sum_valid_o !== 1'b1 || count_o !== 8'd2 || sum_o !== 64'd123) begin
      n_fail++; $display("FAIL start_in_acc: ok=%0b sv=%0b cnt=%0d sum=%0d want 1 1 2 123",
                         ok, sum_valid_o, count_o, sum_o);
    end
    drain(0, 64'd123, 2, 1'b0, ok);
  endtask

  task automatic test_max_len();
    bit ok;
    logic [DW:0] exp;
    vals = {};
    for (int i = 0; i < 255; i++) vals.push_back({$urandom(), $urandom()});
    exp = model();
    do_start(255);
    feed(0, ok);
    n_checks++;
    if (ok !== 1'b1 || sum_valid_o !== 1'b1 || count_o !== 8'd255 ||
        sum_o !== exp[DW-1:0] || overflow_o !== exp[DW]) begin
      n_fail++; $display("FAIL max_len: ok=%0b sv=%0b cnt=%0d sum=%0h ovf=%0b want 1 1 255 %0h %0b",
                         ok, sum_valid_o, count_o, sum_o, overflow_o, exp[DW-1:0], exp[DW]);
    end
    drain(2, exp[DW-1:0], 255, exp[DW], ok);
    n_checks++;
    if (ok !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL max_len_drain: ok=%0b busy=%0b want 1 0", ok, busy_o);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [DW:0] exp;
    for (int it = 0; it < 25; it++) begin
      int len = int'($urandom_range(1, 8));
      vals = {};
      for (int i = 0; i < len; i++)
        vals.push_back(($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom(), $urandom()});
      exp = model();
      do_start(len);
      feed(-1, ok);
      n_checks++;
      if (ok !== 1'b1 || sum_valid_o !== 1'b1 || sum_o !== exp[DW-1:0] ||
          count_o !== CW'(len) || overflow_o !== exp[DW]) begin
        n_fail++; $display("FAIL random_%0d: ok=%0b sv=%0b sum=%0h cnt=%0d ovf=%0b want 1 1 %0h %0d %0b",
                           it, ok, sum_valid_o, sum_o, count_o, overflow_o, exp[DW-1:0], len, exp[DW]);
      end
      drain(int'($urandom_range(0, 4)), exp[DW-1:0], len, exp[DW], ok);
      n_checks++;
      if (ok !== 1'b1 || sum_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL random_drain_%0d: ok=%0b sv=%0b want 1 0", it, ok, sum_valid_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_len_zero();
    test_reset_abort();
    test_start_in_acc();
    test_max_len();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
